// File: rtl/count_seq_monitor.sv
// count_seq_monitor
//   Watches the count bus of an upstream mod-MOD counter. Acquires the
//   sequence 0..MOD-1, locks after LOCK_LEN consecutive correct samples,
//   then reports wraps and flags the first sequence break as a sticky fault.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active high (overrides everything)
//   en        in   sample qualifier; count is only looked at when en=1
//   count     in   [CW-1:0] value from the upstream counter
//   err_clr   in   leaves FAULT (en not required); ignored in other states
//   locked    out  1 while locked onto the sequence
//   wrap_tick out  one-cycle pulse on each legal (MOD-1)->0 step while locked
//   wrap_cnt  out  [WRAP_W-1:0] wraps seen while locked, modulo 2^WRAP_W
//   err       out  1 while in FAULT
//   err_cnt   out  [ERR_W-1:0] faults detected, saturating
module count_seq_monitor #(
    parameter int MOD      = 5,
    parameter int CW       = 3,
    parameter int LOCK_LEN = 4,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CW-1:0]     count,
    input  logic              err_clr,
    output logic              locked,
    output logic              wrap_tick,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int RW = $clog2(LOCK_LEN + 1);
    localparam logic [RW-1:0]    LOCK_RUN = RW'(LOCK_LEN);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {ACQ, TRACK, LOCKED, FAULT} state_t;

    state_t        state;
    logic [CW-1:0] prev;
    logic [RW-1:0] run;

    logic [CW-1:0] exp_val;
    logic          legal;
    logic          hit;

    assign exp_val = (prev == CW'(MOD - 1)) ? '0 : prev + 1'b1;
    // one extra bit so a MOD of 2^CW does not truncate to zero
    assign legal   = ({1'b0, count} < (CW + 1)'(MOD));
    assign hit     = legal && (count == exp_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACQ;
            prev      <= '0;
            run       <= '0;
            locked    <= 1'b0;
            wrap_tick <= 1'b0;
            wrap_cnt  <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            wrap_tick <= 1'b0;
            case (state)
                ACQ: begin
                    // illegal values are simply skipped while acquiring
                    if (en && legal) begin
                        prev <= count;
                        run  <= RW'(1);
                        if (LOCK_LEN == 1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (en) begin
                        if (hit) begin
                            prev <= count;
                            if (run == LOCK_RUN - 1'b1) begin
                                run    <= LOCK_RUN;
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                run <= run + 1'b1;
                            end
                        end else if (legal) begin
                            // a legal break restarts the streak from this sample
                            prev <= count;
                            run  <= RW'(1);
                        end else begin
                            state <= ACQ;
                            run   <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (en) begin
                        if (hit) begin
                            prev <= count;
                            // hit with count 0 can only follow prev==MOD-1
                            if (count == '0) begin
                                wrap_tick <= 1'b1;
                                wrap_cnt  <= wrap_cnt + 1'b1;
                            end
                        end else begin
                            // takes priority over a same-cycle err_clr
                            state  <= FAULT;
                            locked <= 1'b0;
                            err    <= 1'b1;
                            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                        end
                    end
                end
                FAULT: begin
                    if (err_clr) begin
                        state <= ACQ;
                        err   <= 1'b0;
                        run   <= '0;
                    end
                end
                default: begin
                    state  <= ACQ;
                    locked <= 1'b0;
                    err    <= 1'b0;
                    run    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_seq_monitor.sv
module tb_count_seq_monitor;

    localparam int MOD = 5;

    logic       clk = 1'b0;
    logic       rst, en, err_clr;
    logic [2:0] count;
    logic       locked, wrap_tick, err;
    logic [7:0] wrap_cnt;
    logic [3:0] err_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    count_seq_monitor dut (
        .clk(clk), .rst(rst), .en(en), .count(count), .err_clr(err_clr),
        .locked(locked), .wrap_tick(wrap_tick), .wrap_cnt(wrap_cnt),
        .err(err), .err_cnt(err_cnt)
    );

    // Reference model: a streak length of consecutive +1 (mod MOD) samples
    // decides locking; once locked any step other than +1 is a fault.
    bit m_locked, m_fault, m_tick;
    int m_streak, m_last, m_wrap, m_errc;

    task automatic model_step();
        int c;
        c = int'(count);
        m_tick = 0;
        if (rst) begin
            m_locked = 0; m_fault = 0; m_streak = 0; m_last = 0;
            m_wrap = 0; m_errc = 0;
        end else if (m_fault) begin
            if (err_clr) begin m_fault = 0; m_streak = 0; end
        end else if (en) begin
            if (m_locked) begin
                if (c < MOD && c == (m_last + 1) % MOD) begin
                    m_last = c;
                    if (c == 0) begin m_tick = 1; m_wrap = (m_wrap + 1) % 256; end
                end else begin
                    m_locked = 0; m_fault = 1;
                    m_errc = (m_errc < 15) ? m_errc + 1 : 15;
                end
            end else if (c >= MOD) begin
                m_streak = 0;
            end else begin
                if (m_streak > 0 && c == (m_last + 1) % MOD) m_streak++;
                else m_streak = 1;
                m_last = c;
                if (m_streak >= 4) m_locked = 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".locked"},    int'(locked),    int'(m_locked));
        chk({tag, ".wrap_tick"}, int'(wrap_tick), int'(m_tick));
        chk({tag, ".wrap_cnt"},  int'(wrap_cnt),  m_wrap);
        chk({tag, ".err"},       int'(err),       int'(m_fault));
        chk({tag, ".err_cnt"},   int'(err_cnt),   m_errc);
    endtask

    // drive one edge; outputs are sampled 1 time unit after the edge
    task automatic step(input bit r, input bit e, input int c, input bit clr);
        rst = r; en = e; count = 3'(c); err_clr = clr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        bit r, e, clr;
        int c;
        bit l, t, er;
        int w, ec;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit r, input bit e, input int c, input bit clr,
                       input bit l, input bit t, input int w,
                       input bit er, input int ec);
        vec_t v;
        v.r = r; v.e = e; v.c = c; v.clr = clr;
        v.l = l; v.t = t; v.w = w; v.er = er; v.ec = ec;
        vq.push_back(v);
    endtask

    task automatic lock_seq();
        for (int i = 0; i < 4; i++) step(0, 1, i, 0);
    endtask

    initial begin
        rst = 1; en = 0; count = 0; err_clr = 0;

        //   rst en cnt clr  lk tk wrap err errc
        add(1, 1, -1, 1,   0, 0, 0, 0, 0);   // count -1 => random
        add(1, 0, -1, 0,   0, 0, 0, 0, 0);
        add(0, 1, 0, 0,    0, 0, 0, 0, 0);
        add(0, 1, 1, 0,    0, 0, 0, 0, 0);
        add(0, 1, 2, 0,    0, 0, 0, 0, 0);
        add(0, 1, 3, 0,    1, 0, 0, 0, 0);   // locked after 4th sample
        add(0, 1, 4, 0,    1, 0, 0, 0, 0);
        add(0, 1, 0, 0,    1, 1, 1, 0, 0);   // wrap
        add(0, 1, 1, 0,    1, 0, 1, 0, 0);
        add(0, 1, 2, 0,    1, 0, 1, 0, 0);
        add(0, 1, 3, 0,    1, 0, 1, 0, 0);
        add(0, 1, 4, 0,    1, 0, 1, 0, 0);
        add(0, 1, 0, 1,    1, 1, 2, 0, 0);   // err_clr ignored while locked
        add(0, 1, 2, 1,    0, 0, 2, 1, 1);   // 1 expected: fault beats err_clr
        for (int i = 0; i < 5; i++)
            add(0, 1, -1, 0, 0, 0, 2, 1, 1); // err held, count ignored
        add(0, 0, 0, 1,    0, 0, 2, 0, 1);   // clear without en
        add(0, 1, 0, 0,    0, 0, 2, 0, 1);
        add(0, 1, 1, 0,    0, 0, 2, 0, 1);
        add(0, 1, 2, 0,    0, 0, 2, 0, 1);
        add(0, 1, 3, 0,    1, 0, 2, 0, 1);   // relock
        add(0, 1, 6, 0,    0, 0, 2, 1, 2);   // illegal while locked
        add(0, 1, 6, 1,    0, 0, 2, 0, 2);
        add(0, 1, 6, 0,    0, 0, 2, 0, 2);   // illegal in ACQ: no error
        add(0, 1, 7, 0,    0, 0, 2, 0, 2);
        add(0, 1, 2, 0,    0, 0, 2, 0, 2);   // acquire mid-sequence
        add(0, 1, 3, 0,    0, 0, 2, 0, 2);
        add(0, 1, 1, 0,    0, 0, 2, 0, 2);   // legal break restarts streak
        add(0, 1, 2, 0,    0, 0, 2, 0, 2);
        add(0, 1, 3, 0,    0, 0, 2, 0, 2);
        add(0, 1, 4, 0,    1, 0, 2, 0, 2);

        foreach (vq[i]) begin
            int c;
            c = (vq[i].c < 0) ? int'($urandom_range(0, 7)) : vq[i].c;
            step(vq[i].r, vq[i].e, c, vq[i].clr);
            chk($sformatf("vec%0d.locked", i),    int'(locked),    int'(vq[i].l));
            chk($sformatf("vec%0d.wrap_tick", i), int'(wrap_tick), int'(vq[i].t));
            chk($sformatf("vec%0d.wrap_cnt", i),  int'(wrap_cnt),  vq[i].w);
            chk($sformatf("vec%0d.err", i),       int'(err),       int'(vq[i].er));
            chk($sformatf("vec%0d.err_cnt", i),   int'(err_cnt),   vq[i].ec);
        end

        // en=0 holds everything while count wanders (prev is 4)
        for (int i = 0; i < 3; i++) begin
            step(0, 0, int'($urandom_range(0, 7)), 0);
            chk("hold.locked", int'(locked), 1);
            chk("hold.err", int'(err), 0);
            chk_model("hold");
        end
        step(0, 1, 0, 0);
        chk("resume.locked", int'(locked), 1);
        chk("resume.wrap_tick", int'(wrap_tick), 1);
        chk_model("resume");

        // 256 wraps from a fresh reset bring wrap_cnt back to 0
        step(1, 0, 0, 0);
        lock_seq();
        step(0, 1, 4, 0);
        for (int p = 0; p < 256; p++)
            for (int v = 0; v < MOD; v++) step(0, 1, v, 0);
        chk("wrap256.wrap_cnt", int'(wrap_cnt), 0);
        chk("wrap256.locked", int'(locked), 1);
        chk_model("wrap256");

        // 16 fault/clear rounds saturate err_cnt at 15
        for (int k = 0; k < 16; k++) begin
            step(0, 1, 7, 0);
            step(0, 0, 0, 1);
            lock_seq();
        end
        chk("errsat.err_cnt", int'(err_cnt), 15);
        chk_model("errsat");

        // reset while locked clears all outputs
        step(1, 1, 4, 0);
        chk("rstlock.locked", int'(locked), 0);
        chk("rstlock.err_cnt", int'(err_cnt), 0);
        chk_model("rstlock");

        // random traffic, mostly in-sequence with occasional faults/clears
        begin
            int nxt;
            nxt = 0;
            for (int i = 0; i < 3000; i++) begin
                bit r, e, clr;
                int c;
                r   = ($urandom_range(0, 299) == 0);
                e   = ($urandom_range(0, 9) < 8);
                clr = ($urandom_range(0, 19) == 0);
                c   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : nxt;
                step(r, e, c, clr);
                if (e && c < MOD) nxt = (c + 1) % MOD;
                chk_model("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
